// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared types, widths and helpers for the EX-stage divide unit
package ex_div_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam int DIV_LATENCY = XLEN + 1;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {
    EX_DIV_OP  = 2'b00,
    EX_DIVU_OP = 2'b01,
    EX_REM_OP  = 2'b10,
    EX_REMU_OP = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: EX-stage <-> divider handshake, operands and result
interface ex_div_ctrl_if;
  import ex_div_ctrl_pkg::*;
  logic start_i;
  div_op_e op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic annul_i;
  logic stall_req_o;
  logic [XLEN-1:0] result_o;
  logic result_valid_o;
  logic busy_o;
  modport master (
    output start_i, op_i, dividend_i, divisor_i, annul_i,
    input  stall_req_o, result_o, result_valid_o, busy_o
  );
  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, annul_i,
    output stall_req_o, result_o, result_valid_o, busy_o
  );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// ex_div_ctrl_div_step: one combinational restoring-division iteration
module ex_div_ctrl_div_step
  import ex_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] trial;
  logic ge;
  assign trial = {rem_in, quo_in[XLEN-1]};
  assign ge = trial >= {1'b0, divisor};
  assign rem_out = ge ? trial[XLEN-1:0] - divisor : trial[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ge};
endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle RV32M DIV/DIVU/REM/REMU unit with pipeline stall request
// Optional last-result cache enabled by defining EX_DIV_CACHE_EN.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_div_ctrl_if.slave bus
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rsel_q, rsel_d, nq_q, nq_d, nr_q, nr_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [XLEN-1:0] rem_s, quo_s, iq, ir, fq, fr, c_quo, c_rem;
  logic sgn, sa, sb, accept, dz, ovf, hit, last, to_done;
  ex_div_ctrl_div_step u_step (
    .rem_in(rem_q), .quo_in(quo_q), .divisor(dvs_q), .rem_out(rem_s), .quo_out(quo_s)
  );
`ifdef EX_DIV_CACHE_EN
  logic c_vld_q, c_vld_d, c_s_q, c_s_d;
  logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  assign hit = c_vld_q && bus.dividend_i == c_a_q && bus.divisor_i == c_b_q && sgn == c_s_q;
  assign c_quo = c_quo_q;
  assign c_rem = c_rem_q;
  // A missing op invalidates the entry until it completes un-annulled
  always_comb begin
    c_vld_d = (accept && !hit) ? 1'b0 : (state_q == DONE && !bus.annul_i) ? 1'b1 : c_vld_q;
    c_a_d = (accept && !hit) ? bus.dividend_i : c_a_q;
    c_b_d = (accept && !hit) ? bus.divisor_i : c_b_q;
    c_s_d = (accept && !hit) ? sgn : c_s_q;
    c_quo_d = to_done ? fq : c_quo_q;
    c_rem_d = to_done ? fr : c_rem_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      c_vld_q <= 1'b0;
      c_s_q <= 1'b0;
      c_a_q <= ZERO_WORD;
      c_b_q <= ZERO_WORD;
      c_quo_q <= ZERO_WORD;
      c_rem_q <= ZERO_WORD;
    end else begin
      c_vld_q <= c_vld_d;
      c_s_q <= c_s_d;
      c_a_q <= c_a_d;
      c_b_q <= c_b_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
    end
`else
  assign hit = 1'b0;
  assign c_quo = ZERO_WORD;
  assign c_rem = ZERO_WORD;
`endif
  always_comb begin
    sgn = !bus.op_i[0];
    sa = sgn & bus.dividend_i[XLEN-1];
    sb = sgn & bus.divisor_i[XLEN-1];
    accept = state_q == IDLE && bus.start_i && !bus.annul_i;
    dz = bus.divisor_i == ZERO_WORD;
    ovf = sgn && bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}} && (&bus.divisor_i);
    last = state_q == BUSY && cnt_q == CNT_W'(XLEN-1);
    iq = hit ? c_quo : dz ? '1 : bus.dividend_i;
    ir = hit ? c_rem : dz ? bus.dividend_i : ZERO_WORD;
    fq = state_q == IDLE ? iq : neg_if(quo_s, nq_q);
    fr = state_q == IDLE ? ir : neg_if(rem_s, nr_q);
    state_d = bus.annul_i ? IDLE : accept ? ((dz || ovf || hit) ? DONE : BUSY) :
              last ? DONE : state_q == BUSY ? BUSY : IDLE;
    to_done = state_d == DONE;
    cnt_d = state_q == BUSY ? cnt_q + CNT_W'(1) : '0;
    rsel_d = accept ? bus.op_i[1] : rsel_q;
    nq_d = accept ? sa ^ sb : nq_q;
    nr_d = accept ? sa : nr_q;
    dvs_d = accept ? neg_if(bus.divisor_i, sb) : dvs_q;
    quo_d = accept ? neg_if(bus.dividend_i, sa) : state_q == BUSY ? quo_s : quo_q;
    rem_d = accept ? ZERO_WORD : state_q == BUSY ? rem_s : rem_q;
    result_d = to_done ? ((accept ? bus.op_i[1] : rsel_q) ? fr : fq) : result_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rsel_q <= 1'b0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      dvs_q <= ZERO_WORD;
      quo_q <= ZERO_WORD;
      rem_q <= ZERO_WORD;
      result_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsel_q <= rsel_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      result_q <= result_d;
    end
  assign bus.stall_req_o = accept || (state_q == BUSY && !bus.annul_i);
  assign bus.result_valid_o = state_q == DONE && !bus.annul_i;
  assign bus.busy_o = state_q != IDLE;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed self-checking bench for ex_div_ctrl
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;
`ifdef EX_DIV_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = DIV_LATENCY;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  ex_div_ctrl_if bus();
  ex_div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int lat = 0;
    int stalls = 1;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.dividend_i = a;
    bus.divisor_i = b;
    #1 check({tag, ".issue_stall"}, 32'(bus.stall_req_o), 32'd1);
    do begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1 lat++;
      if (!bus.result_valid_o && bus.stall_req_o) stalls++;
    end while (!bus.result_valid_o && lat < 60);
    check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat_exp));
    check({tag, ".result"}, bus.result_o, exp);
    check({tag, ".done_stall"}, 32'(bus.stall_req_o), 32'd0);
    @(negedge clk);
    #1 check({tag, ".one_pulse"}, 32'(bus.result_valid_o), 32'd0);
    check({tag, ".held"}, bus.result_o, exp);
    check({tag, ".idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    logic seen;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.op_i = EX_DIV_OP;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    #1 check("rst.stall", 32'(bus.stall_req_o), 32'd0);
    check("rst.valid", 32'(bus.result_valid_o), 32'd0);
    check("rst.busy", 32'(bus.busy_o), 32'd0);
    check("rst.result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("divu_100_7", EX_DIVU_OP, 32'd100, 32'd7, 32'd14, DIV_LATENCY);
    run_op("remu_100_7", EX_REMU_OP, 32'd100, 32'd7, 32'd2, HIT_LAT);
    run_op("div_m7_2", EX_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LATENCY);
    run_op("rem_m7_2", EX_REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT_LAT);
    run_op("div_7_m2", EX_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LATENCY);
    run_op("div_m7_m2", EX_DIV_OP, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, DIV_LATENCY);
    run_op("divu_5_0", EX_DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", EX_REM_OP, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", EX_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", EX_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_big", EX_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LATENCY);
    run_op("remu_big", EX_REMU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, HIT_LAT);
    run_op("divu_max_1", EX_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, DIV_LATENCY);

    // annul at iteration 10, then reissue immediately
    seen = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = EX_DIVU_OP;
    bus.dividend_i = 32'd1000;
    bus.divisor_i = 32'd10;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1 seen |= bus.result_valid_o;
    end
    bus.annul_i = 1'b1;
    #1 check("annul.stall_drop", 32'(bus.stall_req_o), 32'd0);
    check("annul.no_valid_now", 32'(bus.result_valid_o), 32'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    #1 check("annul.idle", 32'(bus.busy_o), 32'd0);
    check("annul.no_valid", 32'(seen | bus.result_valid_o), 32'd0);
    run_op("annul.reissue", EX_DIVU_OP, 32'd1000, 32'd10, 32'd100, DIV_LATENCY);

    // asynchronous reset at iteration 20
    seen = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = EX_DIVU_OP;
    bus.dividend_i = 32'h0000_FFFF;
    bus.divisor_i = 32'd3;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst = 1'b0;
    #1 check("areset.stall", 32'(bus.stall_req_o), 32'd0);
    check("areset.busy", 32'(bus.busy_o), 32'd0);
    check("areset.valid", 32'(bus.result_valid_o), 32'd0);
    check("areset.result", bus.result_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 seen |= bus.result_valid_o | bus.busy_o;
    end
    check("areset.quiet", 32'(seen), 32'd0);

    run_op("div_1000_3", EX_DIV_OP, 32'd1000, 32'd3, 32'd333, DIV_LATENCY);
    run_op("rem_1000_3", EX_REM_OP, 32'd1000, 32'd3, 32'd1, HIT_LAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
